// File: rtl/fetch_cycle.sv
// IF stage: owns PCF, issues one outstanding fetch at a time on a valid/ready
// instruction-memory port and drives the IF/ID register feeding decode.
module fetch_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    // Handshake: a request transfers on any rising edge where imem_req_valid and
    // imem_req_ready are both high; exactly one imem_rsp_valid pulse answers it later.

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pcf_q;
    logic        kill_q;
    logic [31:0] hold_data_q;
    logic [31:0] hold_pc_q;
    logic [31:0] instr_d_q;
    logic [31:0] pc_d_q;
    logic [31:0] pc_plus4_d_q;
    logic        valid_d_q;

    logic        req_fire;
    logic [31:0] target_aligned;
    logic [31:0] pcf_plus4;
    logic        deliver_en;
    logic [31:0] deliver_data;
    logic [31:0] deliver_pc;

    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_addr      = pcf_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign target_aligned = {PCTargetE[31:2], 2'b00};
    assign pcf_plus4      = pcf_q + 32'd4;

    // A redirect or a decode stall always blocks delivery; a killed response never delivers.
    always_comb begin
        deliver_en   = 1'b0;
        deliver_data = imem_rsp_data;
        deliver_pc   = pcf_q;
        if (state_q == S_HOLD) begin
            deliver_data = hold_data_q;
            deliver_pc   = hold_pc_q;
            deliver_en   = !PCSrcE && !StallD;
        end else if (state_q == S_WAIT) begin
            deliver_en   = !PCSrcE && !StallD && imem_rsp_valid && !kill_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pcf_q        <= RESET_PC;
            kill_q       <= 1'b0;
            hold_data_q  <= 32'd0;
            hold_pc_q    <= 32'd0;
            instr_d_q    <= NOP_INSTR;
            pc_d_q       <= 32'd0;
            pc_plus4_d_q <= 32'd0;
            valid_d_q    <= 1'b0;
        end else begin
            // IF/ID: flush bubbles, stall holds, otherwise deliver or bubble.
            if (FlushD || !StallD) begin
                if (!FlushD && deliver_en) begin
                    instr_d_q    <= deliver_data;
                    pc_d_q       <= deliver_pc;
                    pc_plus4_d_q <= deliver_pc + 32'd4;
                    valid_d_q    <= 1'b1;
                end else begin
                    instr_d_q    <= NOP_INSTR;
                    valid_d_q    <= 1'b0;
                end
            end

            case (state_q)
                S_REQ: begin
                    if (PCSrcE) begin
                        pcf_q <= target_aligned;
                    end
                    if (req_fire) begin
                        state_q <= S_WAIT;
                        kill_q  <= PCSrcE;
                    end
                end
                S_WAIT: begin
                    if (PCSrcE) begin
                        pcf_q <= target_aligned;
                        if (imem_rsp_valid) begin
                            state_q <= S_REQ;
                            kill_q  <= 1'b0;
                        end else begin
                            kill_q  <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (!StallD) begin
                            pcf_q   <= pcf_plus4;
                            state_q <= S_REQ;
                        end else begin
                            hold_data_q <= imem_rsp_data;
                            hold_pc_q   <= pcf_q;
                            state_q     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (PCSrcE) begin
                        pcf_q   <= target_aligned;
                        state_q <= S_REQ;
                    end else if (!StallD) begin
                        pcf_q   <= pcf_plus4;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

    assign InstrD   = instr_d_q;
    assign PCD      = pc_d_q;
    assign PCPlus4D = pc_plus4_d_q;
    assign ValidD   = valid_d_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed and constrained-random bench for fetch_cycle with a sequence-level
// reference PC model for the randomized memory-latency run.
module tb_fetch_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcsrc = 1'b0;
    logic [31:0] target = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'd0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    int checks = 0;
    int errors = 0;

    fetch_cycle dut (
        .clk            (clk),
        .rst            (rst),
        .PCSrcE         (pcsrc),
        .PCTargetE      (target),
        .StallD         (stall),
        .FlushD         (flush),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_addr      (addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .InstrD         (instr_d),
        .PCD            (pc_d),
        .PCPlus4D       (pc_plus4_d),
        .ValidD         (valid_d)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] f_instr(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return {a[23:0], 8'h33} ^ 32'h0010_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept the pending request now, answer it with f_instr(a) on the next cycle.
    task automatic fetch_one(input logic [31:0] a);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = f_instr(a);
        tick();
        rsp_valid = 1'b0;
    endtask

    logic [31:0] ref_pc;
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;
    int          deliveries;
    logic        acc, st_e, pc_e, rv_e;
    logic [31:0] tg_e, ad_e;

    initial begin
        // T1 reset
        tick();
        tick();
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_instr", instr_d, 32'h0000_0013);
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_pcd", pc_d, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_valid", {31'd0, req_valid}, 32'd1);
        chk("post_rst_addr", addr, 32'd0);

        // T2 first fetch
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("wait_req_valid", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = 32'h0050_0093;
        tick();
        rsp_valid = 1'b0;
        chk("t2_instr", instr_d, 32'h0050_0093);
        chk("t2_pcd", pc_d, 32'd0);
        chk("t2_pcp4", pc_plus4_d, 32'd4);
        chk("t2_valid", {31'd0, valid_d}, 32'd1);
        chk("t2_next_addr", addr, 32'd4);

        // T3 stall over the response for 0x4
        stall = 1'b1;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = f_instr(32'h4);
        tick();
        rsp_valid = 1'b0;
        tick();
        chk("t3_hold_pcd", pc_d, 32'd0);
        chk("t3_hold_instr", instr_d, 32'h0050_0093);
        chk("t3_hold_valid", {31'd0, valid_d}, 32'd1);
        chk("t3_no_req", {31'd0, req_valid}, 32'd0);
        stall = 1'b0;
        tick();
        chk("t3_instr", instr_d, f_instr(32'h4));
        chk("t3_pcd", pc_d, 32'h4);
        chk("t3_pcp4", pc_plus4_d, 32'h8);
        chk("t3_valid", {31'd0, valid_d}, 32'd1);
        chk("t3_next_addr", addr, 32'h8);

        // T4 redirect in S_WAIT
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        pcsrc = 1'b1;
        target = 32'h0000_0103;
        tick();
        pcsrc = 1'b0;
        chk("t4_wait_no_req", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_BEEF;
        tick();
        rsp_valid = 1'b0;
        chk("t4_stale_valid", {31'd0, valid_d}, 32'd0);
        chk("t4_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t4_addr", addr, 32'h100);
        fetch_one(32'h100);
        chk("t4_pcd", pc_d, 32'h100);
        chk("t4_instr", instr_d, f_instr(32'h100));
        chk("t4_valid", {31'd0, valid_d}, 32'd1);

        // T4 redirect in S_HOLD
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        stall = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = f_instr(32'h104);
        tick();
        rsp_valid = 1'b0;
        pcsrc = 1'b1;
        target = 32'h0000_0203;
        tick();
        pcsrc = 1'b0;
        stall = 1'b0;
        chk("t4h_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t4h_addr", addr, 32'h200);
        chk("t4h_held_pcd", pc_d, 32'h100);
        fetch_one(32'h200);
        chk("t4h_pcd", pc_d, 32'h200);
        chk("t4h_instr", instr_d, f_instr(32'h200));

        // T5 redirect + response + stall in the same cycle
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        pcsrc = 1'b1;
        target = 32'h0000_0300;
        stall = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = f_instr(32'h204);
        tick();
        pcsrc = 1'b0;
        stall = 1'b0;
        rsp_valid = 1'b0;
        chk("t5_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t5_addr", addr, 32'h300);
        chk("t5_held_pcd", pc_d, 32'h200);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_valid", {31'd0, valid_d}, 32'd0);
        chk("t5_flush_instr", instr_d, 32'h0000_0013);
        chk("t5_flush_pcd", pc_d, 32'h200);
        chk("t5_flush_addr", addr, 32'h300);
        chk("t5_flush_req", {31'd0, req_valid}, 32'd1);
        fetch_one(32'h300);
        chk("t5_pcd", pc_d, 32'h300);
        chk("t5_valid", {31'd0, valid_d}, 32'd1);

        // Redirect in S_REQ on the accepting cycle, then on a refused cycle
        req_ready = 1'b1;
        pcsrc = 1'b1;
        target = 32'h0000_0400;
        tick();
        req_ready = 1'b0;
        pcsrc = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = f_instr(32'h304);
        tick();
        rsp_valid = 1'b0;
        chk("acc_redir_valid", {31'd0, valid_d}, 32'd0);
        chk("acc_redir_addr", addr, 32'h400);
        pcsrc = 1'b1;
        target = 32'h0000_0502;
        tick();
        pcsrc = 1'b0;
        chk("nacc_redir_addr", addr, 32'h500);
        chk("nacc_redir_req", {31'd0, req_valid}, 32'd1);

        // T6 wrap
        pcsrc = 1'b1;
        target = 32'hFFFF_FFFC;
        tick();
        pcsrc = 1'b0;
        chk("wrap_addr", addr, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC);
        chk("wrap_pcd", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pcp4", pc_plus4_d, 32'd0);
        chk("wrap_next_addr", addr, 32'd0);

        // T6 random latency / stall / redirect against a reference PC sequence
        pcsrc = 1'b1;
        target = 32'h0000_0040;
        tick();
        pcsrc = 1'b0;
        ref_pc = 32'h40;
        pend = 1'b0;
        pend_addr = 32'd0;
        cnt = 0;
        deliveries = 0;
        for (int i = 0; i < 2000; i++) begin
            rsp_valid = pend && (cnt == 0);
            rsp_data  = rsp_valid ? f_instr(pend_addr) : $urandom;
            req_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            pcsrc     = ($urandom_range(0, 11) == 0);
            target    = {20'd0, 12'($urandom_range(0, 4095))};
            #1;
            acc  = req_valid && req_ready;
            ad_e = addr;
            st_e = stall;
            pc_e = pcsrc;
            tg_e = target;
            rv_e = rsp_valid;
            tick();
            if (!st_e && valid_d) begin
                deliveries++;
                chk("rand_pcd", pc_d, ref_pc);
                chk("rand_instr", instr_d, f_instr(ref_pc));
                ref_pc = ref_pc + 32'd4;
            end
            if (pc_e) ref_pc = {tg_e[31:2], 2'b00};
            if (rv_e) begin
                pend = 1'b0;
            end else if (pend) begin
                cnt--;
            end
            if (acc) begin
                pend      = 1'b1;
                pend_addr = ad_e;
                cnt       = $urandom_range(0, 7);
            end
        end
        rsp_valid = 1'b0;
        pcsrc = 1'b0;
        stall = 1'b0;
        chk("rand_progress", {31'd0, deliveries > 50}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
